// File: rtl/add4.sv
// add4: four-operand unsigned adder with an overflow monitor.
//   {ov, sum} = (a + b + c + d) mod 2^(WIDTH+1). The top carry bit of the
//   exact sum is dropped on purpose.
//   The adder is a carry-save tree: row 1 compresses a/b/c, row 2 folds in d,
//   and a ripple carry-propagate adder closes it over WIDTH+1 bits.
//   The monitor keeps a sticky overflow flag and a saturating count of
//   overflow cycles.
// Optional build macro: ADD4_REG_OUT_EN
//   When defined, sum/ov are registered (1-cycle latency, cleared by rst), and
//   the monitor then watches the registered ov.
//   When undefined (default), sum/ov are purely combinational.
module add4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum,
  output logic             ov,
  output logic             ov_sticky,
  output logic [CNT_W-1:0] ov_cnt
);

  // Width of the kept result: WIDTH sum bits plus the ov bit.
  localparam int SW = WIDTH + 1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    if (&v) begin
      return v;
    end
    return v + one;
  endfunction

  // Row 1 outputs: bitwise sum and carry of a, b, c. Carry bit i has weight 2^(i+1).
  logic [WIDTH-1:0] r1_s;
  logic [WIDTH-1:0] r1_c;

  // Row 2 operands, aligned to SW bits. The row-1 carries shift up by one.
  logic [SW-1:0]    r2_x;
  logic [SW-1:0]    r2_y;
  logic [SW-1:0]    r2_z;

  // Row 2 outputs. Only the carries below bit SW-1 land inside the kept width.
  logic [SW-1:0]    r2_s;
  logic [SW-2:0]    r2_c;

  // Carry-propagate adder operands and result.
  logic [SW-1:0]    cpa_p;
  logic [SW-1:0]    cpa_q;
  logic [SW-1:0]    cpa_sum;
  logic             cpa_cy;

  // Overflow seen by the monitor.
  logic             ov_mon;

  // Row 1: full-adder row compressing a, b, c into a sum vector and a carry vector.
  always_comb begin
    r1_s = '0;
    r1_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r1_s[i] = a[i] ^ b[i] ^ c[i];
      r1_c[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign r2_x = {1'b0, r1_s};
  assign r2_y = {r1_c, 1'b0};
  assign r2_z = {1'b0, d};

  // Row 2: full-adder row folding d into the row-1 vectors. Carries out of the top bit are dropped.
  always_comb begin
    r2_s = '0;
    r2_c = '0;
    for (int i = 0; i < SW; i++) begin
      r2_s[i] = r2_x[i] ^ r2_y[i] ^ r2_z[i];
    end
    for (int i = 0; i < SW - 1; i++) begin
      r2_c[i] = (r2_x[i] & r2_y[i]) | (r2_x[i] & r2_z[i]) | (r2_y[i] & r2_z[i]);
    end
  end

  assign cpa_p = r2_s;
  assign cpa_q = {r2_c, 1'b0};

  // Final ripple carry-propagate adder. The carry out of the top bit is the discarded S[WIDTH+1].
  always_comb begin
    cpa_sum = '0;
    cpa_cy  = 1'b0;
    for (int i = 0; i < SW; i++) begin
      cpa_sum[i] = cpa_p[i] ^ cpa_q[i] ^ cpa_cy;
      cpa_cy     = (cpa_p[i] & cpa_q[i]) | (cpa_cy & (cpa_p[i] ^ cpa_q[i]));
    end
  end

`ifdef ADD4_REG_OUT_EN
  logic [WIDTH-1:0] sum_p1;
  logic             ov_p1;

  // ---- stage p0 -> p1: registered result, cleared by reset ----
  // Capture the adder result each edge so sum/ov have a 1-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1 <= '0;
      ov_p1  <= 1'b0;
    end else begin
      sum_p1 <= cpa_sum[WIDTH-1:0];
      ov_p1  <= cpa_sum[WIDTH];
    end
  end

  assign sum    = sum_p1;
  assign ov     = ov_p1;
  assign ov_mon = ov_p1;
`else
  assign sum    = cpa_sum[WIDTH-1:0];
  assign ov     = cpa_sum[WIDTH];
  assign ov_mon = cpa_sum[WIDTH];
`endif

  // ---- monitor stage: sticky flag and saturating event counter ----
  // Track overflow history. Reset wins over an overflow on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_sticky <= 1'b0;
      ov_cnt    <= '0;
    end else if (ov_mon) begin
      ov_sticky <= 1'b1;
      ov_cnt    <= sat_inc(ov_cnt);
    end
  end

endmodule

// File: tb/tb_add4.sv
// tb_add4: scoreboard bench for add4 in its default combinational build.
// Expected {ov,sum} values are pushed when operands are driven and popped
// when the outputs are sampled. A reference model tracks the monitor state.
module tb_add4;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic [W-1:0]  d;
  logic [W-1:0]  sum;
  logic          ov;
  logic          ov_sticky;
  logic [CW-1:0] ov_cnt;

  int checks = 0;
  int errors = 0;

  logic [W:0]    sb_q[$];
  logic          exp_ov_now = 1'b0;
  logic          m_sticky = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  add4 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .sum(sum), .ov(ov), .ov_sticky(ov_sticky), .ov_cnt(ov_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference monitor model, driven by the bench's own overflow prediction.
  always @(posedge clk) begin
    if (rst) begin
      m_sticky <= 1'b0;
      m_cnt    <= '0;
    end else if (exp_ov_now) begin
      m_sticky <= 1'b1;
      if (m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
    end
  end

  task automatic drive_ops(input int ia, input int ib, input int ic, input int id);
    int s;
    logic [W:0] e;
    @(negedge clk);
    a = ia[W-1:0];
    b = ib[W-1:0];
    c = ic[W-1:0];
    d = id[W-1:0];
    s = (ia + ib + ic + id) % 32;
    e = s[W:0];
    sb_q.push_back(e);
    exp_ov_now = e[W];
  endtask

  task automatic test_reset;
    logic [W:0] e;
    rst = 1'b1;
    drive_ops(0, 0, 0, 0);
    #1;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 5'h1f;
    checks++;
    if ({ov, sum} !== e) begin
      errors++;
      $display("FAIL reset_sum got %0d want %0d", {ov, sum}, e);
    end
    @(posedge clk); #1;
    checks++;
    if (ov_sticky !== 1'b0 || ov_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_monitor got sticky=%0b cnt=%0d want sticky=0 cnt=0", ov_sticky, ov_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [W:0] e;
    drive_ops(1, 2, 3, 4);
    #1;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 5'h1f;
    checks++;
    if ({ov, sum} !== e || e !== 5'd10) begin
      errors++;
      $display("FAIL basic_sum got %0d want %0d", {ov, sum}, e);
    end
    @(posedge clk); #1;
    checks++;
    if (ov_sticky !== 1'b0 || ov_cnt !== 8'd0) begin
      errors++;
      $display("FAIL basic_monitor got sticky=%0b cnt=%0d want sticky=0 cnt=0", ov_sticky, ov_cnt);
    end
  endtask

  task automatic test_first_ov;
    logic [W:0] e;
    drive_ops(15, 1, 0, 0);
    #1;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 5'h00;
    checks++;
    if ({ov, sum} !== e || e !== 5'b10000) begin
      errors++;
      $display("FAIL first_ov_sum got %0d want %0d", {ov, sum}, e);
    end
    @(posedge clk); #1;
    checks++;
    if (ov_sticky !== 1'b1 || ov_cnt !== 8'd1) begin
      errors++;
      $display("FAIL first_ov_monitor got sticky=%0b cnt=%0d want sticky=1 cnt=1", ov_sticky, ov_cnt);
    end
  endtask

  task automatic test_hold_no_ov;
    logic [W:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_ops(8, 8, 8, 8);
      #1;
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 5'h1f;
      checks++;
      if ({ov, sum} !== e || e !== 5'd0) begin
        errors++;
        $display("FAIL hold_sum cycle %0d got %0d want %0d", i, {ov, sum}, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ov_sticky !== 1'b1 || ov_cnt !== 8'd1) begin
      errors++;
      $display("FAIL hold_monitor got sticky=%0b cnt=%0d want sticky=1 cnt=1", ov_sticky, ov_cnt);
    end
  endtask

  task automatic test_saturate;
    logic [W:0] e;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive_ops(15, 15, 15, 15);
      #1;
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 5'h00;
      checks++;
      if ({ov, sum} !== e || e !== 5'b11100) begin
        errors++;
        if (bad < 5) $display("FAIL sat_sum cycle %0d got %0d want %0d", i, {ov, sum}, e);
        bad++;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ov_sticky !== 1'b1 || ov_cnt !== 8'd255 || ov_cnt !== m_cnt) begin
      errors++;
      $display("FAIL sat_count got sticky=%0b cnt=%0d want sticky=1 cnt=255", ov_sticky, ov_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic [W:0] e;
    rst = 1'b1;
    drive_ops(15, 15, 15, 15);
    #1;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 5'h00;
    checks++;
    if ({ov, sum} !== e) begin
      errors++;
      $display("FAIL rst_mid_sum_before got %0d want %0d", {ov, sum}, e);
    end
    @(posedge clk); #1;
    checks++;
    if (ov_sticky !== 1'b0 || ov_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_monitor got sticky=%0b cnt=%0d want sticky=0 cnt=0", ov_sticky, ov_cnt);
    end
    checks++;
    if ({ov, sum} !== 5'b11100) begin
      errors++;
      $display("FAIL rst_mid_sum_after got %0d want %0d", {ov, sum}, 5'b11100);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep;
    logic [W:0] e;
    int bad = 0;
    for (int i = 0; i < 65536; i++) begin
      drive_ops(i & 15, (i >> 4) & 15, (i >> 8) & 15, (i >> 12) & 15);
      #1;
      e = (sb_q.size() > 0) ? sb_q.pop_front() : ~{ov, sum};
      checks++;
      if ({ov, sum} !== e) begin
        errors++;
        if (bad < 5) $display("FAIL sweep op=%0h got %0d want %0d", i, {ov, sum}, e);
        bad++;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ov_sticky !== m_sticky || ov_cnt !== m_cnt) begin
      errors++;
      $display("FAIL sweep_monitor got sticky=%0b cnt=%0d want sticky=%0b cnt=%0d",
               ov_sticky, ov_cnt, m_sticky, m_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    test_reset();
    test_basic();
    test_first_ov();
    test_hold_no_ov();
    test_saturate();
    test_reset_mid();
    test_sweep();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add4.md
Name: add4

Overview:
- Four-operand unsigned adder: combinational sum of a, b, c, d, truncated to WIDTH bits, plus one overflow/carry bit `ov`.
- Small clocked monitor alongside: sticky overflow flag and saturating overflow-event counter.
- Used as a datapath leaf wherever four small operands are summed in one step; the monitor gives status/debug visibility.

Parameters:
- WIDTH, 4, operand and `sum` width in bits (minimum 2).
- CNT_W, 8, width of the overflow-event counter.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- a  input  WIDTH  operand 0, unsigned.
- b  input  WIDTH  operand 1, unsigned.
- c  input  WIDTH  operand 2, unsigned.
- d  input  WIDTH  operand 3, unsigned.
- sum  output  WIDTH  low WIDTH bits of a+b+c+d.
- ov  output  1  bit WIDTH of a+b+c+d.
- ov_sticky  output  1  registered; set once `ov` has been seen high since reset.
- ov_cnt  output  CNT_W  registered; count of cycles with `ov` high, saturating.

Behaviour:
- Arithmetic:
  - Exact sum S = a+b+c+d needs WIDTH+2 bits.
  - {ov, sum} = S mod 2^(WIDTH+1).
  - sum = S[WIDTH-1:0]; ov = S[WIDTH].
  - S[WIDTH+1] is discarded by design.
  - WIDTH=4 examples: 60 gives sum=12, ov=1; 32 gives sum=0, ov=0; 16 gives sum=0, ov=1.
- sum/ov timing:
  - Purely combinational; zero-cycle latency; no dependence on clk or rst (default build).
  - Must settle within the same cycle the operands change.
- Adder structure:
  - Carry-save reduction: first full-adder row compresses a, b, c; second row adds d.
  - Final ripple carry-propagate adder over WIDTH+1 bits.
  - Behaviourally equivalent to a plain '+'.
- Monitor, on each rising clk edge:
  - rst=1: ov_sticky <= 0, ov_cnt <= 0.
  - Else if ov=1: ov_sticky <= 1; ov_cnt <= ov_cnt+1 unless already all-ones (holds at 2^CNT_W-1, no wrap).
  - Else: both hold.
- Reset values: ov_sticky=0, ov_cnt=0. sum/ov have no reset value; they always reflect the current operands.
- rst asserted mid-operation:
  - Monitor clears on that edge, even if ov=1 in the same cycle; reset wins.
  - sum/ov unaffected.
- No handshake; operands are sampled every cycle.
- X/Z on operands are not specified; the bench drives only known values.

Optional Feature:
- Macro ADD4_REG_OUT_EN.
- Defined:
  - sum and ov are registered: updated on the rising clk edge from the current operands, giving exactly 1-cycle latency.
  - rst=1 clears sum and ov to 0.
  - The monitor is then driven by the registered ov, so ov_sticky/ov_cnt trail the operands by 2 cycles.
- Undefined (default):
  - sum/ov combinational as above.
  - Monitor samples combinational ov, so it trails the operands by 1 cycle.

Test Plan:
- a=b=c=d=0 -> sum=0, ov=0 immediately; after rst pulse ov_sticky=0, ov_cnt=0.
- a=1, b=2, c=3, d=4 -> sum=10, ov=0 in the same cycle; monitor unchanged.
- a=15, b=1, c=0, d=0 -> sum=0, ov=1; next edge ov_sticky=1, ov_cnt=1.
- a=b=c=d=8 -> sum=0, ov=0 (bit 5 dropped); hold 3 cycles -> ov_cnt unchanged.
- a=b=c=d=15 held for 300 cycles -> sum=12, ov=1 throughout; ov_cnt saturates at 255.
- Exhaustive sweep of all 65536 operand sets -> {ov,sum} == (a+b+c+d) mod 32 each cycle.
- rst=1 with ov=1 on the same edge -> ov_sticky=0, ov_cnt=0 afterwards; sum/ov unchanged.
